memory_cycle: RTL and testbench

MEMORY_CYCLE -- requirements
Module: memory_cycle

---
 rtl/memory_cycle_pkg.sv | 73 +++++++
 rtl/memory_cycle_data_memory.sv | 25 ++
 rtl/memory_cycle.sv | 108 ++++++++++
 tb/tb_memory_cycle.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_cycle_pkg.sv
// rtl/memory_cycle_pkg.sv - shared pipeline encodings and M-stage byte-lane helpers
package memory_cycle_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    function automatic size_e load_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

    // Stores have no unsigned variants, so 100/101 fall through to word.
    function automatic size_e store_size(input logic [2:0] f3);
        case (f3)
            F3_B:    return SZ_BYTE;
            F3_H:    return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_lanes(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the low bits puts them in every lane; the enables pick the right one.
    function automatic logic [31:0] store_data(input size_e sz, input logic [31:0] wd);
        case (sz)
            SZ_BYTE: return {4{wd[7:0]}};
            SZ_HALF: return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                                 input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'b0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'b0, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/memory_cycle_data_memory.sv
// rtl/memory_cycle_data_memory.sv - word-wide data memory, byte-enable write, async read
module data_memory #(
    parameter int DMEM_DEPTH = 256
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [3:0]                    be,
    input  logic [$clog2(DMEM_DEPTH)-1:0] addr,
    input  logic [31:0]                   wdata,
    output logic [31:0]                   rdata
);

    logic [31:0] mem [DMEM_DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - pipeline M stage and M/W register; MISALIGN_CHECK_EN adds misalign trapping
module memory_cycle
    import memory_cycle_pkg::*;
#(
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] InstrM,
    input  logic [4:0]  RdM,
    output logic [31:0] ResultW,
    output logic [4:0]  RdW,
    output logic        RegWriteW
`ifdef MISALIGN_CHECK_EN
    ,
    output logic        MisalignW
`endif
);

    localparam int AW = $clog2(DMEM_DEPTH);

    logic [2:0]  f3;
    logic [1:0]  off;
    size_e       st_size;
    logic        st_block;
    logic        ld_block;
    logic        mem_we;
    logic [31:0] rd_word;
    logic [31:0] load_data;
    logic        unused_bits;

    assign f3      = InstrM[14:12];
    assign off     = ALUResultM[1:0];
    assign st_size = store_size(f3);

`ifdef MISALIGN_CHECK_EN
    assign st_block = MemWriteM && misaligned(st_size, off);
    assign ld_block = (ResultSrcM == RES_MEM) && misaligned(load_size(f3), off);
`else
    assign st_block = 1'b0;
    assign ld_block = 1'b0;
`endif

    assign mem_we      = MemWriteM && !rst && !st_block;
    assign unused_bits = ^{ALUResultM[31:AW+2], InstrM[31:15], InstrM[11:0]};

    data_memory #(.DMEM_DEPTH(DMEM_DEPTH)) u_dmem (
        .clk   (clk),
        .we    (mem_we),
        .be    (store_lanes(st_size, off)),
        .addr  (ALUResultM[AW+1:2]),
        .wdata (store_data(st_size, WriteDataM)),
        .rdata (rd_word)
    );

    assign load_data = load_extract(rd_word, f3, off);

    logic        reg_write_q;
    logic [1:0]  res_src_q;
    logic [31:0] alu_q;
    logic [31:0] pc4_q;
    logic [31:0] load_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q <= 1'b0;
            res_src_q   <= RES_ALU;
            RdW         <= 5'd0;
            alu_q       <= 32'd0;
            pc4_q       <= 32'd0;
            load_q      <= 32'd0;
        end else begin
            reg_write_q <= RegWriteM && !ld_block;
            res_src_q   <= ResultSrcM;
            RdW         <= RdM;
            alu_q       <= ALUResultM;
            pc4_q       <= PCPlus4M;
            load_q      <= load_data;
        end
    end

`ifdef MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            MisalignW <= 1'b0;
        end else begin
            MisalignW <= st_block || ld_block;
        end
    end
`endif

    assign RegWriteW = reg_write_q && (RdW != 5'd0);

    always_comb begin
        case (res_src_q)
            RES_MEM: ResultW = load_q;
            RES_PC4: ResultW = pc4_q;
            default: ResultW = alu_q;
        endcase
    end

endmodule

// File: tb/tb_memory_cycle.sv
// tb/tb_memory_cycle.sv - randomized bench for memory_cycle against a byte-array reference model
module tb_memory_cycle;

    localparam int DEPTH = 256;
    localparam int MEMB  = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M, InstrM;
    logic [4:0]  RdM;
    logic [31:0] ResultW;
    logic [4:0]  RdW;
    logic        RegWriteW;
`ifdef MISALIGN_CHECK_EN
    logic        MisalignW;
`endif

    memory_cycle #(.DMEM_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .PCPlus4M   (PCPlus4M),
        .InstrM     (InstrM),
        .RdM        (RdM),
        .ResultW    (ResultW),
        .RdW        (RdW),
        .RegWriteW  (RegWriteW)
`ifdef MISALIGN_CHECK_EN
        ,
        .MisalignW  (MisalignW)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] mdl [0:MEMB-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [2:0] f3);
        int unsigned ba;
        logic [31:0] v;
        ba = a % MEMB;
        case (f3)
            3'd0: v = {{24{mdl[ba][7]}}, mdl[ba]};
            3'd4: v = {24'b0, mdl[ba]};
            3'd1, 3'd5: begin
                ba = ba - ba % 2;
                v = {16'b0, mdl[ba+1], mdl[ba]};
                if (f3 == 3'd1 && v[15]) v[31:16] = 16'hFFFF;
            end
            default: begin
                ba = ba - ba % 4;
                v = {mdl[ba+3], mdl[ba+2], mdl[ba+1], mdl[ba]};
            end
        endcase
        return v;
    endfunction

    task automatic mdl_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
        int unsigned ba;
        ba = a % MEMB;
        if (f3 == 3'd0) begin
            mdl[ba] = wd[7:0];
        end else if (f3 == 3'd1) begin
            ba = ba - ba % 2;
            mdl[ba] = wd[7:0]; mdl[ba+1] = wd[15:8];
        end else begin
            ba = ba - ba % 4;
            for (int k = 0; k < 4; k++) mdl[ba+k] = 8'(wd >> (8*k));
        end
    endtask

    function automatic logic ld_mis(input logic [1:0] src, input logic [31:0] a, input logic [2:0] f3);
`ifdef MISALIGN_CHECK_EN
        if (src != 2'b01) return 1'b0;
        if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
        if (f3 == 3'd1 || f3 == 3'd5) return a % 2 != 0;
        return a % 4 != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic st_mis(input logic we, input logic [31:0] a, input logic [2:0] f3);
`ifdef MISALIGN_CHECK_EN
        if (!we || f3 == 3'd0) return 1'b0;
        if (f3 == 3'd1) return a % 2 != 0;
        return a % 4 != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One M-stage instruction: drive, advance one clock, compare W against the model.
    task automatic op(input logic we, input logic rw, input logic [1:0] src, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] pc4, input logic [2:0] f3,
                      input logic [4:0] rd);
        logic [31:0] exp_res;
        logic        lm, sm;
        lm = ld_mis(src, a, f3);
        sm = st_mis(we, a, f3);
        if (src == 2'b01)      exp_res = mdl_load(a, f3);
        else if (src == 2'b10) exp_res = pc4;
        else                   exp_res = a;
        RegWriteM = rw; MemWriteM = we; ResultSrcM = src; ALUResultM = a;
        WriteDataM = wd; PCPlus4M = pc4; InstrM = {17'h0, f3, 12'h003}; RdM = rd;
        step();
        if (we && !sm) mdl_store(a, f3, wd);
        check("reg_write_w", 32'(RegWriteW), 32'(rw && rd != 5'd0 && !lm));
        check("rd_w", 32'(RdW), 32'(rd));
        if (!lm) check("result_w", ResultW, exp_res);
`ifdef MISALIGN_CHECK_EN
        check("misalign_w", 32'(MisalignW), 32'(lm || sm));
`endif
        MemWriteM = 1'b0; RegWriteM = 1'b0;
    endtask

    initial begin
        rst = 1'b1; RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; ALUResultM = 0;
        WriteDataM = 0; PCPlus4M = 0; InstrM = 0; RdM = 0;
        step(); step();
        check("rst_reg_write", 32'(RegWriteW), 32'd0);
        check("rst_rd", 32'(RdW), 32'd0);
        check("rst_result", ResultW, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) op(1, 0, 2'b00, 32'(i * 4), $urandom(), 0, 3'd2, 0);

        op(0, 1, 2'b00, 32'h55, 0, 0, 3'd2, 5'd3);
        rst = 1'b1;
        RegWriteM = 1; MemWriteM = 1; ALUResultM = 32'h10; WriteDataM = 32'hDEADBEEF;
        InstrM = {17'h0, 3'd2, 12'h023}; RdM = 5'd9;
        step(); step();
        check("rst_store_reg_write", 32'(RegWriteW), 32'd0);
        check("rst_store_result", ResultW, 32'd0);
        rst = 1'b0; MemWriteM = 0; RegWriteM = 0;
        op(0, 1, 2'b01, 32'h10, 0, 0, 3'd2, 5'd7);
        check("rst_no_write", 32'(ResultW == 32'hDEADBEEF), 32'd0);

        op(1, 0, 2'b00, 32'h10, 32'h12345678, 0, 3'd2, 0);
        op(0, 1, 2'b01, 32'h10, 0, 0, 3'd2, 5'd5);
        check("lw_word", ResultW, 32'h12345678);
        check("lw_rd", 32'(RdW), 32'd5);
        op(1, 0, 2'b00, 32'h13, 32'h80, 0, 3'd0, 0);
        op(0, 1, 2'b01, 32'h13, 0, 0, 3'd0, 5'd6);
        check("lb_sign", ResultW, 32'hFFFFFF80);
        op(0, 1, 2'b01, 32'h13, 0, 0, 3'd4, 5'd6);
        check("lbu_zero", ResultW, 32'h00000080);
        op(0, 1, 2'b01, 32'h10, 0, 0, 3'd2, 5'd6);
        check("lw_after_sb", ResultW, 32'h80345678);
        op(1, 0, 2'b00, 32'h402, 32'hBEEF, 0, 3'd1, 0);
        op(0, 1, 2'b01, 32'h002, 0, 0, 3'd5, 5'd8);
        check("lhu_wrap", ResultW, 32'h0000BEEF);
        op(0, 1, 2'b01, 32'h002, 0, 0, 3'd1, 5'd8);
        check("lh_wrap", ResultW, 32'hFFFFBEEF);
        op(0, 1, 2'b10, 32'h77, 0, 32'h104, 3'd2, 5'd1);
        check("pc4_select", ResultW, 32'h104);
        op(0, 1, 2'b00, 32'h77, 0, 0, 3'd2, 5'd0);
        check("x0_no_write", 32'(RegWriteW), 32'd0);
`ifdef MISALIGN_CHECK_EN
        op(1, 0, 2'b00, 32'h21, 32'hAAAAAAAA, 0, 3'd2, 0);
        check("mis_store_flag", 32'(MisalignW), 32'd1);
        op(0, 0, 2'b00, 0, 0, 0, 3'd0, 0);
        check("mis_flag_one_cycle", 32'(MisalignW), 32'd0);
        op(0, 1, 2'b01, 32'h20, 0, 0, 3'd2, 5'd4);
        check("mis_store_suppressed", 32'(ResultW == 32'hAAAAAAAA), 32'd0);
        op(0, 1, 2'b01, 32'h22, 0, 0, 3'd2, 5'd4);
        check("mis_load_no_write", 32'(RegWriteW), 32'd0);
`else
        op(0, 1, 2'b01, 32'h13, 0, 0, 3'd1, 5'd2);
        check("lh_offset3", ResultW, 32'hFFFF8034);
`endif

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            int kind;
            kind = $urandom_range(0, 3);
            a = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, MEMB - 1));
            case (kind)
                0: op(1, 0, 2'($urandom_range(0, 3)), a, $urandom(), $urandom(),
                      3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
                1: op(0, 1, 2'b01, a, $urandom(), $urandom(),
                      3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
                2: op(0, 1, 2'b10, a, $urandom(), $urandom(),
                      3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
                default: op(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00,
                            a, $urandom(), $urandom(), 3'($urandom_range(0, 7)),
                            5'($urandom_range(0, 31)));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
